// File: rtl/cycle_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cycle_ctrl_pkg
// Description : Shared constants and types for the picoMIPS cycle sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package cycle_ctrl_pkg;

    localparam int CYCLE_SIZE     = 2;
    localparam int EXEC_CNT_WIDTH = 4;

    localparam logic [CYCLE_SIZE-1:0] CYCLE_FETCH  = 2'd0;
    localparam logic [CYCLE_SIZE-1:0] CYCLE_DECODE = 2'd1;
    localparam logic [CYCLE_SIZE-1:0] CYCLE_EXEC   = 2'd2;
    localparam logic [CYCLE_SIZE-1:0] CYCLE_INC    = 2'd3;

    // The first four encodings match the cycle code so the phase output is a
    // direct slice of the state; HALT sits outside that range.
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_INC    = 3'd3,
        ST_HALT   = 3'd4
    } ctrl_state_t;

endpackage : cycle_ctrl_pkg
`default_nettype wire

// File: rtl/cycle_ctrl_exec_counter.sv
`default_nettype none
// ============================================================================
// Module      : exec_counter
// Description : Loadable down-counter with zero flag; times the execute phase.
// Revision    : 1.0 - initial release
// ============================================================================
module exec_counter
    import cycle_ctrl_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load,
    input  logic [EXEC_CNT_WIDTH-1:0] load_val,
    input  logic                      dec,
    output logic                      zero
);

    logic [EXEC_CNT_WIDTH-1:0] cnt_q;
    logic [EXEC_CNT_WIDTH-1:0] cnt_d;

    // Load takes priority; decrement saturates at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule : exec_counter
`default_nettype wire

// File: rtl/cycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cycle_ctrl
// Description : picoMIPS multi-cycle sequencer: phase code, execute stretching
//               for multiply / input-wait, branch qualify, write strobe, halt.
// Revision    : 1.0 - initial release
// ============================================================================
module cycle_ctrl
    import cycle_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 4
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    input  logic                  dec_writes,
    input  logic                  dec_mul,
    input  logic                  dec_wait,
    input  logic                  dec_halt,
    input  logic                  branch_taken,
    input  logic                  in_valid,
    output logic                  in_ack,
    output logic [CYCLE_SIZE-1:0] cycle,
    output logic                  branch,
    output logic                  reg_we,
    output logic                  halted
);

    localparam logic [EXEC_CNT_WIDTH-1:0] MUL_LOAD = EXEC_CNT_WIDTH'(MUL_CYCLES - 1);

    ctrl_state_t state_q, state_d;
    logic        writes_q, writes_d;
    logic        mul_q,    mul_d;
    logic        wait_q,   wait_d;
    logic        taken_q,  taken_d;

    logic                      cnt_load;
    logic [EXEC_CNT_WIDTH-1:0] cnt_load_val;
    logic                      cnt_dec;
    logic                      cnt_zero;
    logic                      in_exec;
    logic                      exec_final;

    // A wait instruction ends on in_valid; everything else ends when the
    // counter reaches zero. Wait overrides multiply.
    always_comb begin
        in_exec    = (state_q == ST_EXEC);
        exec_final = in_exec && (wait_q ? in_valid : cnt_zero);
    end

    // Next-state, flag capture and counter control.
    always_comb begin
        state_d      = state_q;
        writes_d     = writes_q;
        mul_d        = mul_q;
        wait_d       = wait_q;
        taken_d      = taken_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = in_exec && !wait_q && mul_q;

        case (state_q)
            ST_FETCH: begin
                if (run) begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                writes_d     = dec_writes;
                mul_d        = dec_mul && !dec_wait;
                wait_d       = dec_wait;
                cnt_load     = 1'b1;
                cnt_load_val = (dec_mul && !dec_wait) ? MUL_LOAD : '0;
                state_d      = dec_halt ? ST_HALT : ST_EXEC;
            end
            ST_EXEC: begin
                if (exec_final) begin
                    taken_d = branch_taken;
                    state_d = ST_INC;
                end
            end
            ST_INC: begin
                state_d = ST_FETCH;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // Sequencer state and flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_FETCH;
            writes_q <= 1'b0;
            mul_q    <= 1'b0;
            wait_q   <= 1'b0;
            taken_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            writes_q <= writes_d;
            mul_q    <= mul_d;
            wait_q   <= wait_d;
            taken_q  <= taken_d;
        end
    end

    exec_counter u_exec_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // Output decode; HALT presents the FETCH phase code.
    always_comb begin
        halted = (state_q == ST_HALT);
        cycle  = halted ? CYCLE_FETCH : state_q[CYCLE_SIZE-1:0];
        branch = (state_q == ST_INC) && taken_q;
        reg_we = exec_final && writes_q;
        in_ack = in_exec && wait_q && in_valid;
    end

endmodule : cycle_ctrl
`default_nettype wire

// File: doc/cycle_ctrl.md
# cycle_ctrl

Multi-cycle sequencer for the picoMIPS core. It generates the `cycle` phase code consumed by the program counter and datapath, and stretches the execute phase for multi-cycle multiplies and for input-wait instructions using a valid/ack handshake. It qualifies the PC `branch` select, produces the register-file write strobe, and parks the core on a halt instruction. It sits between the instruction decoder and the `pc`, ALU and register file.

## Interface
Parameters:
- MUL_CYCLES, 4, execute-phase length of a multiply, legal range 1..15
- Cycle code width is `CYCLE_SIZE` (2 bits) from the shared package, not a parameter.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; all state and outputs forced to reset values while low
- run  in  1  start/continue enable, sampled only in FETCH
- dec_writes  in  1  decoded instruction writes a register
- dec_mul  in  1  decoded instruction is multiply
- dec_wait  in  1  decoded instruction waits on external input
- dec_halt  in  1  decoded instruction is halt
- branch_taken  in  1  branch condition from decoder/ALU, valid in EXEC
- in_valid  in  1  external input data valid
- in_ack  out  1  one-cycle acknowledge of external input
- cycle  out  `CYCLE_SIZE`  phase: FETCH=0, DECODE=1, EXEC=2, INC=3
- branch  out  1  PC branch select
- reg_we  out  1  register-file write strobe
- halted  out  1  core parked

## Operation
- States: FETCH, DECODE, EXEC, INC, HALT. `cycle` is the state code; HALT drives FETCH code.
- FETCH: if run=1, go to DECODE; otherwise hold.
- DECODE: register dec_* flags into flag registers. dec_halt=1 → HALT (takes priority over all other flags). Otherwise → EXEC. Load exec counter with MUL_CYCLES-1 if dec_mul, else 0.
- EXEC for a non-wait instruction: decrement the counter each cycle. The final EXEC cycle is the one where the counter is 0. Go to INC after the final EXEC cycle.
- EXEC for a wait instruction: hold until in_valid=1. In that cycle in_ack=1 and the cycle counts as the final EXEC cycle.
- If both wait and mul are set, wait governs and mul is ignored.
- reg_we=1 only in the final EXEC cycle, and only when the registered writes flag is set.
- In the final EXEC cycle, sample branch_taken into a register.
- INC: branch = registered taken AND INC. Always go to FETCH.
- HALT: halted=1, all strobes 0, exit only by reset. run is ignored in HALT.
- run deasserted mid-instruction has no effect until the FETCH check.
- dec_* inputs are ignored outside DECODE. branch_taken is ignored outside the final EXEC cycle.

## Timing
- Reset values: state FETCH, cycle=0, branch=0, reg_we=0, in_ack=0, halted=0, counter 0, flag registers 0.
- Ordinary instruction: 4 cycles from FETCH to FETCH.
- Multiply: 3+MUL_CYCLES cycles.
- Wait: 4+N cycles, where N is the number of EXEC cycles with in_valid=0.
- Outputs are decoded from registered state only (Moore), except in_ack and reg_we on a wait, which are combinational on in_valid in EXEC.
- in_valid held high across instructions is acknowledged once per wait instruction, never in other states.
- branch is high for exactly one cycle (INC), so `pc` sees it only in the increment phase.
- Reset asserted mid-EXEC or in HALT: immediate return to FETCH with all outputs at reset values. No ack or write is issued.
- Reset release: the first transition is evaluated at the next rising clk.

## Structure
- Shared `constants.sv` package additions:
  - `CYCLE_SIZE`
  - `CYCLE_FETCH`, `CYCLE_DECODE`, `CYCLE_EXEC`, `CYCLE_INC`
  - state enum typedef `ctrl_state_t`
  - `EXEC_CNT_WIDTH` (4)
- One natural sub-module: `exec_counter` (loadable down-counter with zero flag). Everything else stays in cycle_ctrl.

## Test plan
- Reset low for 2 cycles, then high with run=1 and an ordinary instruction (dec_writes=1): cycle sequence is 0,1,2,3,0. reg_we is high only in the cycle=2 cycle. branch stays 0.
- MUL_CYCLES=4, dec_mul=1: cycle=2 for exactly 4 cycles. reg_we is high only on the 4th. Total 7 cycles.
- dec_wait=1, in_valid raised 5 cycles into EXEC: in_ack=1 and reg_we=1 in the same single cycle, then INC. A held in_valid produces no second ack until the next wait instruction's EXEC.
- branch_taken=1 in the final EXEC cycle: branch=1 only during cycle=3. branch_taken=1 only in a non-final EXEC cycle of a multiply: branch stays 0.
- dec_halt=1 together with dec_mul=1: enter HALT after DECODE, halted=1, cycle=0, and no reg_we, branch or in_ack while toggling run and in_valid. Reset low restores halted=0.
- Reset asserted during a wait EXEC with in_valid=1: in_ack and reg_we drop immediately. After release, state is FETCH.
